xup_tff_counter_ctrl: RTL and testbench
=======================================

# xup_tff_counter_ctrl

Controller that sequences a bank of WIDTH enabled T flip-flops as a synchronous up/down counter for Basys3 lab designs. It derives the per-bit toggle and enable vectors each cycle and applies them to the bank. It also supports run/stop, single-step, parallel load and a built-in prescaler. It sits between board-level controls (debounced buttons, switches) and display or compare logic that consumes `q`.

## Interface
- `WIDTH`, 4: number of T flip-flops in the bank (≥1).
- `PRESCALE`, 1: clock cycles per count event while running (≥1).

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: enter RUN (level sampled per cycle).
- `stop` in 1: enter IDLE.
- `step` in 1: one count event, IDLE only.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `load` in 1: parallel load request.
- `load_val` in WIDTH: value loaded into the bank.
- `q` out WIDTH: bank state.
- `busy` out 1: high in RUN.
- `tc` out 1: terminal-count pulse.

## Operation
- One clock domain; reset is asynchronous and active-high.
- Reset values: `q`=0, `busy`=0, `tc`=0, state=IDLE, prescaler=0.
- States:
  - IDLE: no automatic counting; `step` produces one count event.
  - RUN: a count event fires when the prescaler reaches PRESCALE-1, then the prescaler returns to 0.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`.
  - Every transition clears the prescaler.
- Per-cycle priority: `load` > `stop` > `start` > `step`/prescaler event. `step` in RUN is ignored.
- Count event toggle vector:
  - up: t[0]=1, t[i]=&q[i-1:0].
  - down: t[0]=1, t[i]=~|q[i-1:0].
  - Enable = 1 for all bits.
- Load: toggle vector = `q ^ load_val` with enable=1. `q`=`load_val` after the edge. The load cycle also clears the prescaler, suppresses any count event that cycle, and leaves the state unchanged.
- Wrap-around: up from all-ones→0; down from 0→all-ones. On that event `tc` is asserted.
- `up` is sampled at the count event. A direction change affects only the next event.
- No count event → enable=0, `q` holds.

## Timing
- All inputs are sampled on the rising edge of `clk`.
- `step` or `load` high in cycle n → `q` updated at the end of cycle n, visible in n+1.
- `start` in cycle n → `busy`=1 from n+1. With the prescaler cleared, the first count lands at the end of cycle n+PRESCALE; later counts follow every PRESCALE cycles.
- `stop` in cycle n → `busy`=0 from n+1. No count at the end of n, even if the prescaler was due.
- `tc` is registered: high for exactly one cycle, the same cycle `q` first shows the wrapped value.
- Simultaneous cases:
  - `start`+`stop` → `stop` wins.
  - `load`+wrap-due event → load wins, no `tc`.
- Reset asserted mid-RUN → all outputs forced to reset values immediately, without waiting for `clk`.

## Configuration
- `XUP_TFF_CTRL_TC_STOP_EN`:
  - Defined: one-shot mode. A wrapping count event in RUN also moves the state to IDLE, so `busy` falls in the same cycle `tc` rises. `q` still wraps.
  - Undefined: free-running; RUN continues through wrap.
- `step`-induced wraps never change state in either mode.

## Structure
- Package `xup_tff_ctrl_pkg`:
  - state encoding constants (IDLE=1'b0, RUN=1'b1);
  - toggle-vector functions for up and down.
- Sub-module `xup_tff_slice`: one enabled T flip-flop.
  - Ports: clk, reset, t, en, q.
  - Async-reset to 0; q ← q^t when en.
  - Instantiated WIDTH times via generate.
- Top level holds the FSM, prescaler, toggle/enable decode and `tc` register.

## Test plan
All scenarios use WIDTH=4, PRESCALE=3 unless noted.
- Reset then `start`, up=1 → `busy`=1; `q` goes 1,2,3 at 3-cycle spacing after `busy` rises; `tc` stays 0.
- `load_val`=4'hE with `load`, then two `step` pulses in IDLE → `q`=E, F, 0; `tc`=1 only in the cycle `q`=0.
- `q`=0, up=0, one `step` → `q`=F, `tc`=1 for one cycle; a further `step` → `q`=E, `tc`=0.
- `start`+`stop` in the same cycle → `busy` stays 0. `load`(5)+`step` in the same cycle → `q`=5, not 6.
- Assert `reset` between clock edges while RUN with `q`=7 → `q`=0, `busy`=0, `tc`=0 immediately; no count on the next edge.
- With `XUP_TFF_CTRL_TC_STOP_EN`, PRESCALE=1: load D, `start`, up=1 → `q` goes E, F, 0; `busy` falls and `tc` rises when `q`=0; `q` then holds 0.

Source files
------------

// File: rtl/xup_tff_ctrl_pkg.sv
// Shared state encoding and T flip-flop toggle-vector helpers for the
// xup_tff_counter_ctrl counter controller.
package xup_tff_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest bank the helpers support; callers zero-extend and truncate.
  localparam int MAX_WIDTH = 32;

  // Bit i toggles when every lower bit is 1 (carry ripple of an incrementer).
  function automatic logic [MAX_WIDTH-1:0] toggle_up(input logic [MAX_WIDTH-1:0] q);
    logic [MAX_WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < MAX_WIDTH; i++) t[i] = t[i-1] & q[i-1];
    return t;
  endfunction

  // Bit i toggles when every lower bit is 0 (borrow ripple of a decrementer).
  function automatic logic [MAX_WIDTH-1:0] toggle_down(input logic [MAX_WIDTH-1:0] q);
    logic [MAX_WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < MAX_WIDTH; i++) t[i] = t[i-1] & ~q[i-1];
    return t;
  endfunction

endpackage

// File: rtl/xup_tff_slice.sv
// One enabled T flip-flop: q toggles on t when en is high; async reset to 0.
module xup_tff_slice (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic en,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (en) q_d = q_q ^ t;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/xup_tff_counter_ctrl.sv
// Up/down counter built from a bank of enabled T flip-flops, with run/stop,
// single-step, parallel load and prescaler. Option macro: XUP_TFF_CTRL_TC_STOP_EN.
module xup_tff_counter_ctrl
  import xup_tff_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             evt, wrap;
  logic [WIDTH-1:0] q_bank, t_vec, en_vec;

  assign wrap = up ? (&q_bank) : (~|q_bank);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    evt     = 1'b0;
    t_vec   = '0;
    en_vec  = '0;

    if (load) begin
      // Load rides the toggle path: flipping exactly the differing bits lands on load_val.
      t_vec  = q_bank ^ load_val;
      en_vec = '1;
      pre_d  = '0;
    end else if (stop) begin
      state_d = IDLE;
      pre_d   = '0;
    end else if (start && state_q == IDLE) begin
      state_d = RUN;
      pre_d   = '0;
    end else if (state_q == IDLE) begin
      evt = step;
    end else if (pre_q == PRE_LAST) begin
      evt   = 1'b1;
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (evt) begin
      t_vec  = up ? WIDTH'(toggle_up(MAX_WIDTH'(q_bank)))
                  : WIDTH'(toggle_down(MAX_WIDTH'(q_bank)));
      en_vec = '1;
      tc_d   = wrap;
`ifdef XUP_TFF_CTRL_TC_STOP_EN
      if (state_q == RUN && wrap) begin
        state_d = IDLE;
        pre_d   = '0;
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    xup_tff_slice u_slice (
      .clk  (clk),
      .reset(reset),
      .t    (t_vec[i]),
      .en   (en_vec[i]),
      .q    (q_bank[i])
    );
  end

  assign q    = q_bank;
  assign busy = (state_q == RUN);
  assign tc   = tc_q;

endmodule

// File: tb/tb_xup_tff_counter_ctrl.sv
// Directed bench for xup_tff_counter_ctrl (WIDTH=4, PRESCALE=3); expectations
// follow XUP_TFF_CTRL_TC_STOP_EN when it is defined.
module tb_xup_tff_counter_ctrl;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 3;

  logic             clk = 1'b0;
  logic             reset, start, stop, step, up, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             busy, tc;

  int n_cmp = 0;
  int n_bad = 0;

  xup_tff_counter_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .busy    (busy),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, tc, q} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async_t0: got busy=%b tc=%b q=%h, want 0 0 0", busy, tc, q);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({busy, tc, q} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b tc=%b q=%h, want 0 0 0", busy, tc, q);
    end
  endtask

  task automatic test_run_up();
    logic [3:0] eq;
    up    = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, tc, q} !== {1'b1, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL run_start: got busy=%b tc=%b q=%h, want 1 0 0", busy, tc, q);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      eq = 4'(k / 3);
      n_cmp++;
      if ({busy, tc, q} !== {1'b1, 1'b0, eq}) begin
        n_bad++;
        $display("FAIL run_up k=%0d: got busy=%b tc=%b q=%h, want 1 0 %h", k, busy, tc, q, eq);
      end
    end
    // Prescaler is now due; stop must win and suppress the count.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if ({busy, tc, q} !== {1'b0, 1'b0, 4'h3}) begin
      n_bad++;
      $display("FAIL stop_due: got busy=%b tc=%b q=%h, want 0 0 3", busy, tc, q);
    end
    tick();
    n_cmp++;
    if ({busy, tc, q} !== {1'b0, 1'b0, 4'h3}) begin
      n_bad++;
      $display("FAIL idle_hold: got busy=%b tc=%b q=%h, want 0 0 3", busy, tc, q);
    end
  endtask

  task automatic test_load_step();
    logic [3:0] exp_q [3] = '{4'hE, 4'hF, 4'h0};
    logic       exp_t [3] = '{1'b0, 1'b0, 1'b1};
    up       = 1'b1;
    load_val = 4'hE;
    for (int i = 0; i < 3; i++) begin
      load = (i == 0);
      step = (i != 0);
      tick();
      load = 1'b0;
      step = 1'b0;
      n_cmp++;
      if ({busy, tc, q} !== {1'b0, exp_t[i], exp_q[i]}) begin
        n_bad++;
        $display("FAIL load_step i=%0d: got busy=%b tc=%b q=%h, want 0 %b %h", i, busy, tc, q, exp_t[i], exp_q[i]);
      end
    end
    tick();
    n_cmp++;
    if ({tc, q} !== {1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL tc_one_cycle: got tc=%b q=%h, want 0 0", tc, q);
    end
  endtask

  task automatic test_step_down();
    logic       dir   [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] exp_q [3] = '{4'hF, 4'hE, 4'hF};
    logic       exp_t [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      up   = dir[i];
      step = 1'b1;
      tick();
      step = 1'b0;
      n_cmp++;
      if ({busy, tc, q} !== {1'b0, exp_t[i], exp_q[i]}) begin
        n_bad++;
        $display("FAIL step_dir i=%0d: got busy=%b tc=%b q=%h, want 0 %b %h", i, busy, tc, q, exp_t[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    n_cmp++;
    if ({busy, q} !== {1'b0, 4'hF}) begin
      n_bad++;
      $display("FAIL start_stop: got busy=%b q=%h, want 0 f", busy, q);
    end
    up       = 1'b1;
    load_val = 4'h5;
    load     = 1'b1;
    step     = 1'b1;
    tick();
    load = 1'b0;
    step = 1'b0;
    n_cmp++;
    if ({tc, q} !== {1'b0, 4'h5}) begin
      n_bad++;
      $display("FAIL load_step_same: got tc=%b q=%h, want 0 5", tc, q);
    end
    // Load while a wrap is due in RUN: load wins, no tc, prescaler restarts.
    load_val = 4'hF;
    load     = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    load_val = 4'h9;
    load     = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++;
    if ({busy, tc, q} !== {1'b1, 1'b0, 4'h9}) begin
      n_bad++;
      $display("FAIL load_over_wrap: got busy=%b tc=%b q=%h, want 1 0 9", busy, tc, q);
    end
    tick();
    tick();
    n_cmp++;
    if (q !== 4'h9) begin
      n_bad++;
      $display("FAIL load_clears_pre: got q=%h, want 9", q);
    end
    tick();
    n_cmp++;
    if ({busy, tc, q} !== {1'b1, 1'b0, 4'hA}) begin
      n_bad++;
      $display("FAIL after_load_count: got busy=%b tc=%b q=%h, want 1 0 a", busy, tc, q);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_wrap_run();
    logic [3:0] eq;
    logic       eb, et;
    up       = 1'b1;
    load_val = 4'hE;
    load     = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      et = (k == 6);
`ifdef XUP_TFF_CTRL_TC_STOP_EN
      eq = (k < 3) ? 4'hE : (k < 6) ? 4'hF : 4'h0;
      eb = (k < 6);
`else
      eq = (k < 3) ? 4'hE : (k < 6) ? 4'hF : (k < 9) ? 4'h0 : 4'h1;
      eb = 1'b1;
`endif
      n_cmp++;
      if ({busy, tc, q} !== {eb, et, eq}) begin
        n_bad++;
        $display("FAIL wrap_run k=%0d: got busy=%b tc=%b q=%h, want %b %b %h", k, busy, tc, q, eb, et, eq);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    load_val = 4'h7;
    load     = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({busy, q} !== {1'b1, 4'h7}) begin
      n_bad++;
      $display("FAIL pre_reset: got busy=%b q=%h, want 1 7", busy, q);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, tc, q} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async_run: got busy=%b tc=%b q=%h, want 0 0 0", busy, tc, q);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, tc, q} !== 6'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got busy=%b tc=%b q=%h, want 0 0 0", busy, tc, q);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    step     = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    test_reset();
    test_run_up();
    test_load_step();
    test_step_down();
    test_simultaneous();
    test_wrap_run();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
